// File: rtl/gf_pow_seq.sv
// Constant-time square-and-multiply engine computing x^e (or x^-1) over GF(2^WIDTH).
// Latency: accept edge + WIDTH RUN steps; the result is held in DONE until taken.
// Backpressure: in_ready is low outside IDLE, and DONE holds out_y/out_valid until out_ready.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake carrying in_x, in_exp, in_inv
//   out_valid/out_ready    result handshake carrying out_y
//   busy                   high while the engine is stepping through the exponent
module gf_pow_seq #(
  parameter int             WIDTH = 6,
  parameter logic [WIDTH:0] POLY  = 7'b1000011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_exp,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  // Unreduced products of two WIDTH-bit polynomials fit in 2*WIDTH-1 bits.
  localparam int PW = 2 * WIDTH - 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Exponent used for inversion: 2^WIDTH - 2 (all ones except bit 0).
  localparam logic [WIDTH-1:0] E_INV = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  // Holds in_ready low until the first clock edge after reset release.
  logic             rdy_q;

  logic             accept;
  logic [WIDTH-1:0] sq_val;
  logic [WIDTH-1:0] prod_val;
  logic [WIDTH-1:0] acc_step;

  // Fold bits WIDTH..PW-1 back down, from the top, using z^WIDTH = POLY - z^WIDTH.
  function automatic logic [WIDTH-1:0] gf_reduce(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW - 1; i >= WIDTH; i--) begin
      if (r[i]) begin
        r = r ^ (PW'(POLY) << (i - WIDTH));
      end
    end
    return r[WIDTH-1:0];
  endfunction

  // Squaring in characteristic 2 is linear: coefficient i moves to position 2i.
  function automatic logic [WIDTH-1:0] gf_sqr(input logic [WIDTH-1:0] a);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[2*i] = a[i];
    end
    return gf_reduce(s);
  endfunction

  // Carry-less shift-and-xor product followed by a single reduction.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        p = p ^ (PW'(a) << i);
      end
    end
    return gf_reduce(p);
  endfunction

  assign accept = in_valid && in_ready;

  // One left-to-right step: the multiply is always evaluated so timing does
  // not depend on the exponent bit, only the selected value does.
  always_comb begin
    sq_val   = gf_sqr(acc_q);
    prod_val = gf_mul(sq_val, x_q);
    acc_step = e_q[cnt_q] ? prod_val : sq_val;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == IDLE) && rdy_q;
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    out_y     = (state_q == DONE) ? acc_q : '0;
  end

  // Operand capture and exponentiation datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      x_q   <= '0;
      e_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= in_x;
            e_q   <= in_inv ? E_INV : in_exp;
            acc_q <= WIDTH'(1);
            cnt_q <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          acc_q <= acc_step;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_pow_seq.sv
// Directed plus randomized checks of gf_pow_seq at WIDTH=6 and WIDTH=4
// against a repeated-multiplication reference model.
module tb_gf_pow_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_x;
  logic [5:0] in_exp;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;
  logic       busy;

  logic       in_valid_4;
  logic       in_ready_4;
  logic [3:0] in_x_4;
  logic [3:0] in_exp_4;
  logic       in_inv_4;
  logic       out_valid_4;
  logic       out_ready_4;
  logic [3:0] out_y_4;
  logic       busy_4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gf_pow_seq #(.WIDTH(6), .POLY(7'b1000011)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_exp(in_exp), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy)
  );

  gf_pow_seq #(.WIDTH(4), .POLY(5'b10011)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_x(in_x_4), .in_exp(in_exp_4), .in_inv(in_inv_4),
    .out_valid(out_valid_4), .out_ready(out_ready_4),
    .out_y(out_y_4), .busy(busy_4)
  );

  // Reference field multiply: classic xtime loop over the bits of b.
  function automatic int ref_mul(input int a, input int b, input int w, input int poly);
    int r = 0;
    for (int i = 0; i < w; i++) begin
      if (b[i]) r = r ^ a;
      a = a << 1;
      if (a[w]) a = a ^ poly;
    end
    return r;
  endfunction

  // Reference power: e repeated multiplications starting from 1 (so x^0 = 1).
  function automatic int ref_pow(input int x, input int e, input int w, input int poly);
    int r = 1;
    for (int i = 0; i < e; i++) r = ref_mul(r, x, w, poly);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=6 operation. hold=0 keeps out_ready high from the accept on;
  // hold>0 withholds out_ready for that many cycles once out_valid is seen.
  // edges = clock edges after the accept edge until out_valid; nbusy = busy samples.
  task automatic run6(input int x, input int e, input int inv, input int hold,
                      output int res, output int edges, output int nbusy);
    int n;
    int expv;
    expv = ref_pow(x, (inv != 0) ? 62 : e, 6, 'h43);
    in_x      = x[5:0];
    in_exp    = e[5:0];
    in_inv    = inv[0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 30) begin
      tick;
      n++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick;
    edges = 0;
    nbusy = 0;
    // Operand lines are scrambled after the accept; they must have no effect.
    while (!out_valid && edges < 40) begin
      if (busy) nbusy++;
      in_valid = 1'($urandom);
      in_x     = 6'($urandom);
      in_exp   = 6'($urandom);
      in_inv   = 1'($urandom);
      tick;
      edges++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    res = int'(out_y);
    chk("pow_result", {26'd0, out_y}, expv);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_x     = 6'($urandom);
      tick;
      chk("hold_out_y", {26'd0, out_y}, expv);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run4(input int x, input int e, input int inv, output int res);
    int n;
    in_x_4     = x[3:0];
    in_exp_4   = e[3:0];
    in_inv_4   = inv[0];
    in_valid_4 = 1'b1;
    n = 0;
    while (!in_ready_4 && n < 30) begin
      tick;
      n++;
    end
    chk("w4_in_ready", {31'd0, in_ready_4}, 32'd1);
    tick;
    in_valid_4 = 1'b0;
    n = 0;
    while (!out_valid_4 && n < 30) begin
      tick;
      n++;
    end
    chk("w4_latency_edges", n, 4);
    res = int'(out_y_4);
    chk("w4_result", {28'd0, out_y_4}, ref_pow(x, (inv != 0) ? 14 : e, 4, 'h13));
    tick;
  endtask

  initial begin
    int res;
    int edges;
    int nbusy;
    int x;
    int e;
    int inv;

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_exp = '0; in_inv = 1'b0; out_ready = 1'b0;
    in_valid_4 = 1'b0; in_x_4 = '0; in_exp_4 = '0; in_inv_4 = 1'b0; out_ready_4 = 1'b1;
    tick;
    tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_y", {26'd0, out_y}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("post_release_in_ready", {31'd0, in_ready}, 32'd1);

    // x^38 with latency: the accept cycle counts as cycle 1, so out_valid
    // arrives in cycle WIDTH+1 = 7 and busy covers the 6 RUN cycles.
    run6('h02, 'h26, 0, 0, res, edges, nbusy);
    chk("pow38_value", res, 'h1B);
    chk("pow38_latency_cycles", edges + 1, 7);
    chk("pow38_busy_cycles", nbusy, 6);

    // Reset in the middle of RUN.
    in_x = 6'h02; in_exp = 6'h26; in_inv = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    rst = 1'b0;
    chk("abort_release_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("abort_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    run6('h02, 'h07, 0, 0, res, edges, nbusy);
    chk("after_abort_value", res, 'h06);

    // Inverse mode, then the full sweep.
    run6('h02, 'h15, 1, 0, res, edges, nbusy);
    chk("inv_z", res, 'h21);
    for (int i = 0; i < 64; i++) begin
      run6(i, 'h15, 1, 0, res, edges, nbusy);
      chk("inv_sweep_product", ref_mul(i, res, 6, 'h43), (i == 0) ? 0 : 1);
    end

    // Boundary exponents and constant time.
    run6('h00, 0, 0, 0, res, edges, nbusy);
    chk("zero_pow_zero", res, 'h01);
    run6('h00, 5, 0, 0, res, edges, nbusy);
    chk("zero_pow_five", res, 'h00);
    run6('h2D, 'h3F, 0, 0, res, edges, nbusy);
    chk("pow_all_ones", res, 'h01);
    chk("ct_e3f_edges", edges, 6);
    run6('h2D, 1, 0, 0, res, edges, nbusy);
    chk("pow_one", res, 'h2D);
    chk("ct_e01_edges", edges, 6);

    // Backpressure with scrambled inputs during RUN and DONE.
    run6('h13, 'h2A, 0, 10, res, edges, nbusy);

    // Randomized operations with random output stalls.
    for (int i = 0; i < 40; i++) begin
      x   = int'($urandom_range(0, 63));
      e   = int'($urandom_range(0, 63));
      inv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run6(x, e, inv, int'($urandom_range(0, 3)), res, edges, nbusy);
    end

    // Second configuration: GF(16) with z^4+z+1.
    run4('h2, 'hE, 0, res);
    chk("w4_inv_z", res, 'h9);
    run4('h2, 'h3, 1, res);
    chk("w4_inv_mode", res, 'h9);
    for (int i = 0; i < 12; i++) begin
      run4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
